// File: rtl/relu_writeback_if.sv
// Stream-in and feature-buffer write bus of relu_writeback.
// The block takes the slave view; the upstream/memory side takes the master view.
interface relu_writeback_if #(
  parameter int dataWidth   = 32,
  parameter int pactivation = 128,
  parameter int addrWidth   = 10
);
  localparam int VW = dataWidth * pactivation;

  logic                 in_valid;
  logic [VW-1:0]        in_data;
  logic                 in_ready;
  logic                 mem_we;
  logic [addrWidth-1:0] mem_addr;
  logic [VW-1:0]        mem_wdata;
  logic                 mem_ready;

  modport master (
    output in_valid,
    output in_data,
    output mem_ready,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  mem_ready,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/relu_writeback.sv
// ReLU activation writeback: buffers vectors (2-entry FIFO + output register), writes them
// to consecutive feature-buffer rows and counts zero-valued lanes for sparsity statistics.
module relu_writeback #(
  parameter int dataWidth   = 32,
  parameter int pactivation = 128,
  parameter int addrWidth   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addrWidth-1:0] baseAddr,
  input  logic [addrWidth:0]   numRows,
  relu_writeback_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          zeroCount
);
  localparam int VW = dataWidth * pactivation;
  localparam int CW = addrWidth + 1;
  localparam int ZW = $clog2(pactivation + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [addrWidth-1:0] base_q, base_d;
  logic [CW-1:0]        num_q, num_d;
  logic [CW-1:0]        accept_cnt_q, accept_cnt_d;
  logic [CW-1:0]        write_cnt_q, write_cnt_d;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                 fifo_rd_q, fifo_rd_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic [VW-1:0]        fifo_mem_q [2];
  logic                 mem_we_q, mem_we_d;
  logic [addrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [VW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]          zero_q, zero_d;

  logic                   in_ready_c;
  logic                   accept;
  logic                   retire;
  logic                   org_free;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   bypass;
  logic [pactivation-1:0] lane_zero;
  logic [ZW-1:0]          zero_lanes;
  logic [32:0]            zero_sum;

  // Zero detection on the vector currently presented to memory.
  for (genvar gi = 0; gi < pactivation; gi++) begin : g_lane
    assign lane_zero[gi] = (mem_wdata_q[dataWidth*gi +: dataWidth] == '0);
  end

  always_comb begin
    zero_lanes = '0;
    for (int i = 0; i < pactivation; i++) begin
      zero_lanes = zero_lanes + ZW'(lane_zero[i]);
    end
    zero_sum = {1'b0, zero_q} + {{(33-ZW){1'b0}}, zero_lanes};
  end

  // Handshake: in_ready depends only on state and occupancy, never on in_valid.
  always_comb begin
    in_ready_c = (state_q == S_RUN) && (accept_cnt_q < num_q) && (fifo_cnt_q < 2'd2);
    accept     = bus.in_valid && in_ready_c;
    retire     = mem_we_q && bus.mem_ready;
    org_free   = !mem_we_q || retire;
    fifo_pop   = org_free && (fifo_cnt_q != 2'd0);
    bypass     = org_free && (fifo_cnt_q == 2'd0) && accept;
    fifo_push  = accept && !bypass;
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    num_d        = num_q;
    accept_cnt_d = accept_cnt_q;
    write_cnt_d  = write_cnt_q;
    fifo_cnt_d   = fifo_cnt_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_wr_d    = fifo_wr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    zero_d       = zero_q;

    if (accept) begin
      accept_cnt_d = accept_cnt_q + CW'(1);
    end
    if (retire) begin
      write_cnt_d = write_cnt_q + CW'(1);
      zero_d      = zero_sum[32] ? 32'hFFFF_FFFF : zero_sum[31:0];
    end

    // The FIFO head always has priority over a bypassing input to keep ordering.
    if (fifo_pop) begin
      mem_we_d    = 1'b1;
      mem_wdata_d = fifo_mem_q[fifo_rd_q];
      fifo_rd_d   = ~fifo_rd_q;
    end else if (bypass) begin
      mem_we_d    = 1'b1;
      mem_wdata_d = bus.in_data;
    end else if (retire) begin
      mem_we_d = 1'b0;
    end

    if (fifo_push) begin
      fifo_wr_d = ~fifo_wr_q;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = baseAddr;
          num_d        = numRows;
          zero_d       = '0;
          accept_cnt_d = '0;
          write_cnt_d  = '0;
          state_d      = (numRows == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (write_cnt_d == num_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address tracks the retired count, so it holds while the memory stalls.
    mem_addr_d = base_d + write_cnt_d[addrWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      accept_cnt_q <= '0;
      write_cnt_q  <= '0;
      fifo_cnt_q   <= '0;
      fifo_rd_q    <= 1'b0;
      fifo_wr_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      zero_q       <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      num_q        <= num_d;
      accept_cnt_q <= accept_cnt_d;
      write_cnt_q  <= write_cnt_d;
      fifo_cnt_q   <= fifo_cnt_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      zero_q       <= zero_d;
    end
  end

  // Storage array needs no reset: occupancy is tracked by fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[fifo_wr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign zeroCount     = zero_q;
endmodule

// File: tb/tb_relu_writeback.sv
// Directed bench for relu_writeback: reset, streaming, backpressure, address wrap,
// zero-length / extra beats and mid-job reset.
module tb_relu_writeback;
  localparam int DW = 32;
  localparam int PA = 128;
  localparam int AW = 10;
  localparam int VW = DW * PA;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_rows = '0;
  logic          busy;
  logic          done;
  logic [31:0]   zero_count;

  relu_writeback_if #(.dataWidth(DW), .pactivation(PA), .addrWidth(AW)) bus ();

  relu_writeback #(.dataWidth(DW), .pactivation(PA), .addrWidth(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .baseAddr  (base_addr),
    .numRows   (num_rows),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .zeroCount (zero_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Edge-indexed record of accepts, retired writes and done pulses.
  int            cyc = 0;
  int            acc_n = 0;
  int            done_n = 0;
  int            done_edge = -1;
  int            acc_edge[$];
  logic [AW-1:0] wr_addr[$];
  int            wr_lane0[$];
  int            wr_edge[$];

  int acc_base = 0;
  int cur_nz = 1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) begin
      acc_n <= acc_n + 1;
      acc_edge.push_back(cyc);
    end
    if (bus.mem_we && bus.mem_ready) begin
      wr_addr.push_back(bus.mem_addr);
      wr_lane0.push_back(int'(bus.mem_wdata[DW-1:0]));
      wr_edge.push_back(cyc);
    end
    if (done) begin
      done_n    <= done_n + 1;
      done_edge <= cyc;
    end
  end

  function automatic logic [VW-1:0] mk_vec(input int v, input int nz);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < nz; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  // Advance to the next falling edge and present the next unaccepted vector.
  task automatic tick();
    @(negedge clk);
    bus.in_data = mk_vec(acc_n - acc_base + 1, cur_nz);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, output int k);
    tick();
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
    tick();
    start = 1'b0;
    k = cyc - 1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_n;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_n != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_we, bus.in_ready, busy, done} !== 4'b0000 || bus.mem_addr !== '0 ||
          bus.mem_wdata !== '0 || zero_count !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc%0d: we=%b rdy=%b busy=%b done=%b addr=%h zc=%0d, required all 0",
                 i, bus.mem_we, bus.in_ready, busy, done, bus.mem_addr, zero_count);
      end
    end
    $display("test_reset: 10 idle cycles checked");
  endtask

  task automatic test_streaming();
    int k, wb, a0, nw;
    bit ok;
    acc_base = acc_n; wb = wr_addr.size(); cur_nz = 1;
    bus.mem_ready = 1'b1; bus.in_valid = 1'b1;
    do_start(10'h010, 11'd4, k);
    wait_done(40, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stream_done: no done within 40 cycles, required done"); end
    nw = wr_addr.size() - wb;
    n_cmp++;
    if (nw != 4) begin n_bad++; $display("FAIL stream_nwrites: got %0d, required 4", nw); end
    a0 = (acc_edge.size() > acc_base) ? acc_edge[acc_base] : -1;
    n_cmp++;
    if (a0 != k + 1) begin n_bad++; $display("FAIL stream_first_accept: edge %0d, required %0d", a0, k + 1); end
    for (int j = 0; j < 4 && wb + j < wr_addr.size(); j++) begin
      n_cmp++;
      if (wr_addr[wb+j] !== AW'(16 + j) || wr_lane0[wb+j] != j + 1 || wr_edge[wb+j] != a0 + 1 + j) begin
        n_bad++;
        $display("FAIL stream_write%0d: addr=%h lane0=%0d edge=%0d, required addr=%h lane0=%0d edge=%0d",
                 j, wr_addr[wb+j], wr_lane0[wb+j], wr_edge[wb+j], AW'(16 + j), j + 1, a0 + 1 + j);
      end
    end
    if (nw == 4) begin
      n_cmp++;
      if (done_edge != wr_edge[wb+3] + 1) begin
        n_bad++;
        $display("FAIL stream_done_timing: done edge %0d, required %0d", done_edge, wr_edge[wb+3] + 1);
      end
    end
    n_cmp++;
    if (zero_count !== 32'd508) begin n_bad++; $display("FAIL stream_zerocount: got %0d, required 508", zero_count); end
    n_cmp++;
    if (acc_n - acc_base != 4) begin n_bad++; $display("FAIL stream_accepts: got %0d, required 4", acc_n - acc_base); end
    bus.in_valid = 1'b0;
    tick();
    $display("test_streaming: %0d writes, zeroCount=%0d", nw, zero_count);
  endtask

  task automatic test_backpressure();
    int k, wb, nw, stable_bad;
    bit ok;
    acc_base = acc_n; wb = wr_addr.size(); cur_nz = 2;
    bus.mem_ready = 1'b0; bus.in_valid = 1'b1;
    do_start(10'h020, 11'd6, k);
    stable_bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.mem_we && (bus.mem_wdata !== mk_vec(1, 2) || bus.mem_addr !== 10'h020)) stable_bad++;
    end
    n_cmp++;
    if (acc_n - acc_base != 3) begin n_bad++; $display("FAIL bp_accepts_stalled: got %0d, required 3", acc_n - acc_base); end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b, required 0", bus.in_ready); end
    n_cmp++;
    if (bus.mem_we !== 1'b1 || stable_bad != 0) begin
      n_bad++;
      $display("FAIL bp_hold: mem_we=%b unstable_cycles=%0d, required mem_we=1 unstable_cycles=0", bus.mem_we, stable_bad);
    end
    bus.mem_ready = 1'b1;
    wait_done(40, ok);
    nw = wr_addr.size() - wb;
    n_cmp++;
    if (!ok || nw != 6) begin n_bad++; $display("FAIL bp_nwrites: done=%b writes=%0d, required done=1 writes=6", ok, nw); end
    for (int j = 0; j < 6 && wb + j < wr_addr.size(); j++) begin
      n_cmp++;
      if (wr_addr[wb+j] !== AW'(32 + j) || wr_lane0[wb+j] != j + 1) begin
        n_bad++;
        $display("FAIL bp_write%0d: addr=%h lane0=%0d, required addr=%h lane0=%0d",
                 j, wr_addr[wb+j], wr_lane0[wb+j], AW'(32 + j), j + 1);
      end
    end
    n_cmp++;
    if (zero_count !== 32'd756) begin n_bad++; $display("FAIL bp_zerocount: got %0d, required 756", zero_count); end
    bus.in_valid = 1'b0;
    tick();
    $display("test_backpressure: %0d writes, zeroCount=%0d", nw, zero_count);
  endtask

  task automatic test_wrap();
    int k, wb, nw;
    bit ok;
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
    acc_base = acc_n; wb = wr_addr.size(); cur_nz = 1;
    bus.mem_ready = 1'b1; bus.in_valid = 1'b1;
    do_start(10'h3FE, 11'd4, k);
    wait_done(40, ok);
    nw = wr_addr.size() - wb;
    n_cmp++;
    if (!ok || nw != 4) begin n_bad++; $display("FAIL wrap_nwrites: done=%b writes=%0d, required done=1 writes=4", ok, nw); end
    for (int j = 0; j < 4 && wb + j < wr_addr.size(); j++) begin
      n_cmp++;
      if (wr_addr[wb+j] !== exp_addr[j]) begin
        n_bad++;
        $display("FAIL wrap_addr%0d: got %h, required %h", j, wr_addr[wb+j], exp_addr[j]);
      end
    end
    n_cmp++;
    if (zero_count !== 32'd508) begin n_bad++; $display("FAIL wrap_zerocount: got %0d, required 508", zero_count); end
    bus.in_valid = 1'b0;
    tick();
    $display("test_wrap: %0d writes starting at 3FE", nw);
  endtask

  task automatic test_zero_and_extra();
    int k, wb, d0, nw;
    bit ok;
    acc_base = acc_n; wb = wr_addr.size(); cur_nz = 1;
    bus.mem_ready = 1'b1; bus.in_valid = 1'b1;
    do_start(10'h050, 11'd0, k);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_done_k1: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || wr_addr.size() != wb || acc_n != acc_base) begin
      n_bad++;
      $display("FAIL zero_nowork: done=%b writes=%0d accepts=%0d, required 0/0/0",
               done, wr_addr.size() - wb, acc_n - acc_base);
    end
    acc_base = acc_n; wb = wr_addr.size(); d0 = done_n;
    do_start(10'h060, 11'd2, k);
    tick();
    base_addr = 10'h100; num_rows = 11'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, ok);
    repeat (4) tick();
    nw = wr_addr.size() - wb;
    n_cmp++;
    if (!ok || acc_n - acc_base != 2 || nw != 2) begin
      n_bad++;
      $display("FAIL extra_counts: done=%b accepts=%0d writes=%0d, required 1/2/2", ok, acc_n - acc_base, nw);
    end
    for (int j = 0; j < 2 && wb + j < wr_addr.size(); j++) begin
      n_cmp++;
      if (wr_addr[wb+j] !== AW'(96 + j) || wr_lane0[wb+j] != j + 1) begin
        n_bad++;
        $display("FAIL extra_write%0d: addr=%h lane0=%0d, required addr=%h lane0=%0d",
                 j, wr_addr[wb+j], wr_lane0[wb+j], AW'(96 + j), j + 1);
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || done_n - d0 != 1) begin
      n_bad++;
      $display("FAIL extra_start_ignored: busy=%b done_pulses=%0d, required busy=0 done_pulses=1", busy, done_n - d0);
    end
    bus.in_valid = 1'b0;
    tick();
    $display("test_zero_and_extra: %0d accepts in second job", acc_n - acc_base);
  endtask

  task automatic test_midjob_reset();
    int k, wb, nw;
    bit ok;
    acc_base = acc_n; wb = wr_addr.size(); cur_nz = 1;
    bus.mem_ready = 1'b0; bus.in_valid = 1'b1;
    do_start(10'h080, 11'd5, k);
    repeat (4) tick();
    bus.mem_ready = 1'b1; tick();
    bus.mem_ready = 1'b0; tick();
    bus.mem_ready = 1'b1; tick();
    bus.mem_ready = 1'b0; tick();
    n_cmp++;
    if (wr_addr.size() - wb != 2 || acc_n - acc_base != 5 || zero_count !== 32'd254) begin
      n_bad++;
      $display("FAIL mid_prereset: writes=%0d accepts=%0d zc=%0d, required 2/5/254",
               wr_addr.size() - wb, acc_n - acc_base, zero_count);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.mem_we !== 1'b0 || zero_count !== 32'd0 || busy !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.mem_addr !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_state: we=%b zc=%0d busy=%b rdy=%b addr=%h, required all 0",
               bus.mem_we, zero_count, busy, bus.in_ready, bus.mem_addr);
    end
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (wr_addr.size() - wb != 2 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_no_more_writes: writes=%0d busy=%b, required 2/0", wr_addr.size() - wb, busy);
    end
    acc_base = acc_n; wb = wr_addr.size();
    do_start(10'h0A0, 11'd2, k);
    wait_done(20, ok);
    nw = wr_addr.size() - wb;
    n_cmp++;
    if (!ok || nw != 2) begin n_bad++; $display("FAIL mid_restart: done=%b writes=%0d, required 1/2", ok, nw); end
    for (int j = 0; j < 2 && wb + j < wr_addr.size(); j++) begin
      n_cmp++;
      if (wr_addr[wb+j] !== AW'(160 + j) || wr_lane0[wb+j] != j + 1) begin
        n_bad++;
        $display("FAIL mid_restart_write%0d: addr=%h lane0=%0d, required addr=%h lane0=%0d",
                 j, wr_addr[wb+j], wr_lane0[wb+j], AW'(160 + j), j + 1);
      end
    end
    n_cmp++;
    if (zero_count !== 32'd254) begin n_bad++; $display("FAIL mid_restart_zc: got %0d, required 254", zero_count); end
    bus.in_valid = 1'b0;
    tick();
    $display("test_midjob_reset: restart wrote %0d rows", nw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_zero_and_extra();
    test_midjob_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
